dither_fill_engine: RTL and testbench
=====================================

Name: dither_fill_engine

Overview:
Parametrised Floyd–Steinberg dither-fill engine. It is the successor to the fixed 3/3/2 dithering cell and sits on the same register-request / drawing-engine bus. It fills a rectangle with one 24-bit colour, quantised per channel to R_BITS/G_BITS/B_BITS using full four-neighbour error diffusion. Output is one byte per pixel into the byte-addressed framebuffer, with one pixel written per accepted bus cycle.

Parameters:
R_BITS, 3, red output bits (1..6)
G_BITS, 3, green output bits (1..6)
B_BITS, 2, blue output bits (1..6); R_BITS+G_BITS+B_BITS must equal 8
FB_WIDTH, 640, framebuffer pitch in pixels
LINE_MAX, 640, error line-buffer depth; maximum rectangle width
ADDR_W, 18, word-address width of de_addr

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
req  in  1  start request, sampled in IDLE only
ack  out  1  one-cycle acceptance pulse
busy  out  1  high from cycle after accept until return to IDLE
r0  in  16  x_start
r1  in  16  y_start
r2  in  16  x_end (inclusive)
r3  in  16  y_end (inclusive)
r4  in  16  {red[7:0], green[7:0]}
r5  in  16  {blue[7:0], unused[7:0]}
de_req  out  1  write request
de_ack  in  1  bus accepts current write this cycle
de_addr  out  ADDR_W  word address = pixel byte address >> 2
de_nbyte  out  4  active-low byte enables; lane = byte address[1:0]
de_rnw  out  1  constant 0
de_w_data  out  32  packed pixel {r,g,b} replicated into all 4 bytes

Behaviour:
- Reset: one clock, synchronous and active-high. rst high forces state IDLE; ack, de_req and busy go to 0; de_nbyte = 4'b1111. Applies mid-operation; the in-flight pixel is abandoned.
- States: IDLE -> CLEAR -> DRAW -> IDLE.
- IDLE, req=1: latch r0..r5, pulse ack one cycle, go to CLEAR. req while not IDLE is ignored.
- Degenerate request (x_end<x_start, y_end<y_start, or width>LINE_MAX): ack pulse, no bus activity, stay IDLE.
- CLEAR: zero error-buffer entries 0..width+1, one entry per cycle. Exit to DRAW after the last entry. busy is high throughout.
- DRAW: de_req held high. de_addr, de_nbyte and de_w_data are derived from registered state and stay stable while de_ack=0.
- Transfer completes on a cycle where de_req and de_ack are both high. After the last pixel transfers, de_req drops next cycle and the block returns to IDLE.
- Throughput: one pixel per cycle while de_ack is held high.
- Scan order: x ascending within a row; rows in ascending y.
- Byte address = x + y*FB_WIDTH, computed at least 20 bits wide.
- Per channel with N bits:
  - v = clamp(c_in + ((acc + 8) >>> 4), 0, 255), where acc is the signed error sum in 1/16 units.
  - q = min((v + 2^(7-N)) >> (8-N), 2^N - 1).
  - err = v - (q << (8-N)), signed.
- Diffusion weights: 7/16 to the right, 3/16 down-left, 5/16 down, 1/16 down-right.
- Error at rectangle edges is discarded: never wraps to the opposite side, never carries past y_end.
- Error accumulators are signed and sized so that 16×max|err|×16 cannot overflow.
- Overlapping pixel fields are forbidden; the packing widths sum to exactly 8.

Optional Feature:
SERPENTINE_EN defined: rows with odd (y - y_start) scan x descending and use a mirrored kernel (7/16 to the left, 3/16 down-right, 1/16 down-left). Not defined: every row scans ascending. Addresses and counts are identical otherwise.

Test Plan:
- Exact colour (r4=16'h2020, r5=16'h4000), rect (0,0)-(3,1), de_ack tied 1 -> 8 writes; addresses 0..3 and 640..643; every byte 8'h25; de_nbyte cycles 1110, 1101, 1011, 0111; ack one cycle; busy low after the last write.
- Saturation (r4=16'hFFFF, r5=16'hFF00), rect (10,5)-(17,6) -> 16 writes, all 8'hFF, no wrap to 0; first byte address 3210.
- Dither density (red 8'h10, green 0, blue 0), rect 8x8 with R_BITS=3 -> red code is only 0 or 1; count of code 1 is 30..34; green and blue codes are 0.
- Backpressure: de_ack low 3 cycles at the 3rd pixel -> de_req, de_addr and de_w_data held stable; total writes unchanged; no pixel skipped or duplicated.
- Reset mid-DRAW, then a new exact-colour request -> de_req=0 and busy=0 the cycle after rst; the second fill matches the fresh-run output bit-for-bit.
- Degenerate request (x_end<x_start) -> one ack pulse; de_req never asserted; busy stays 0; req ignored while busy.

Source files
------------

// File: rtl/dither_fill_engine_if.sv
// dither_fill_engine_if: register-request handshake plus drawing-engine write bus
// Ports: master = requester/bus side (drives req, r0..r5, de_ack);
//        slave  = fill engine (drives ack, busy and the de_* write signals).
interface dither_fill_engine_if #(
  parameter int ADDR_W = 18
);
  logic              req;
  logic              ack;
  logic              busy;
  logic [15:0]       r0, r1, r2, r3, r4, r5;
  logic              de_req;
  logic              de_ack;
  logic [ADDR_W-1:0] de_addr;
  logic [3:0]        de_nbyte;
  logic              de_rnw;
  logic [31:0]       de_w_data;
  modport master (
    output req, r0, r1, r2, r3, r4, r5, de_ack,
    input  ack, busy, de_req, de_addr, de_nbyte, de_rnw, de_w_data
  );
  modport slave (
    input  req, r0, r1, r2, r3, r4, r5, de_ack,
    output ack, busy, de_req, de_addr, de_nbyte, de_rnw, de_w_data
  );
endinterface

// File: rtl/dither_fill_engine.sv
// dither_fill_engine: Floyd-Steinberg dithered solid-colour rectangle fill, one byte per pixel
// Ports: clk, rst (synchronous, active-high);
//        bus (slave): req/ack/busy request handshake, r0..r5 = x_start, y_start, x_end,
//        y_end, {red,green}, {blue,-}; de_* = framebuffer write bus, one pixel per accepted cycle.
// Optional: define SERPENTINE_EN to scan odd rows right-to-left with a mirrored kernel.
module dither_fill_engine #(
  parameter int R_BITS   = 3,
  parameter int G_BITS   = 3,
  parameter int B_BITS   = 2,
  parameter int FB_WIDTH = 640,
  parameter int LINE_MAX = 640,
  parameter int ADDR_W   = 18
) (
  input logic clk,
  input logic rst,
  dither_fill_engine_if.slave bus
);
  localparam int LW = LINE_MAX + 2;
  localparam int IW = $clog2(LW);
  localparam int BW = ADDR_W + 2;
  localparam int NB [3] = '{R_BITS, G_BITS, B_BITS};
  localparam logic [IW-1:0] ONE = IW'(1);
  typedef enum logic [1:0] {IDLE, CLEAR, DRAW} state_t;
  state_t state_q;
  logic ack_q, busy_q, de_req_q;
  logic [15:0] xs_q, y_q, ye_q;
  logic [IW-1:0] w_q, col_q, cnt_q;
  logic [7:0] c_q [3];
`ifdef SERPENTINE_EN
  logic odd_q;
`endif
  // Error line buffer: entry p+1 holds the diffused error for column p; entries 0 and
  // width+1 are edge slots so neighbour writes never need a bounds check.
  logic signed [15:0] eb_q [3][LW];
  // a_q: next-row error for the column just behind the scan position (still missing
  // its 3/16 share); b_q: next-row error for the current column; r_q: 7/16 carried forward.
  logic signed [15:0] a_q [3], b_q [3], r_q [3];
  logic signed [15:0] acc [3], err [3], wval [3], a_d [3], b_d [3], r_d [3];
  logic signed [16:0] v [3];
  logic [8:0] vc [3], q [3], qm [3];
  logic desc, first, last_col, last_px, fire, bypass, we, degen;
  logic [IW-1:0] wr_idx;
  logic [16:0] wd;
  logic [BW-1:0] byte_addr;
  logic [7:0] pix;
  always_comb begin
`ifdef SERPENTINE_EN
    desc = odd_q;
`else
    desc = 1'b0;
`endif
    first = desc ? col_q == w_q - ONE : col_q == '0;
    last_col = desc ? col_q == '0 : col_q == w_q - ONE;
    last_px = last_col && y_q == ye_q;
    fire = de_req_q && bus.de_ack;
`ifdef SERPENTINE_EN
    // The row's first pixel sits where the previous row ended, so its error is the
    // still-registered pending value rather than a buffer entry.
    bypass = first;
    we = !first;
    wr_idx = desc ? col_q + ONE + ONE : col_q;
`else
    // The previous row's last next-row value is flushed on this row's first pixel,
    // whose own down-left share falls off the edge; width 1 reads it back directly.
    bypass = first && w_q == ONE;
    we = 1'b1;
    wr_idx = first ? w_q : col_q;
`endif
    for (int c = 0; c < 3; c++) begin
      acc[c] = (bypass ? a_q[c] : eb_q[c][col_q + ONE]) + r_q[c];
      v[c] = $signed({9'b0, c_q[c]}) + 17'((acc[c] + 16'sd8) >>> 4);
      vc[c] = v[c] < 17'sd0 ? 9'd0 : v[c] > 17'sd255 ? 9'd255 : v[c][8:0];
      q[c] = (vc[c] + (9'd1 << (7 - NB[c]))) >> (8 - NB[c]);
      qm[c] = q[c] > 9'((1 << NB[c]) - 1) ? 9'((1 << NB[c]) - 1) : q[c];
      err[c] = 16'(vc[c]) - 16'(qm[c] << (8 - NB[c]));
      wval[c] = first ? a_q[c] : a_q[c] + 16'sd3 * err[c];
      a_d[c] = b_q[c] + 16'sd5 * err[c];
      b_d[c] = last_col ? 16'sd0 : err[c];
      r_d[c] = last_col ? 16'sd0 : 16'sd7 * err[c];
    end
    pix = {qm[0][R_BITS-1:0], qm[1][G_BITS-1:0], qm[2][B_BITS-1:0]};
    byte_addr = BW'(32'(xs_q) + 32'(col_q) + 32'(y_q) * 32'(FB_WIDTH));
    wd = {1'b0, bus.r2} - {1'b0, bus.r0} + 17'd1;
    degen = bus.r2 < bus.r0 || bus.r3 < bus.r1 || wd > 17'(LINE_MAX);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q <= 1'b0;
      busy_q <= 1'b0;
      de_req_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.req) begin
          ack_q <= 1'b1;
          xs_q <= bus.r0;
          y_q <= bus.r1;
          ye_q <= bus.r3;
          w_q <= wd[IW-1:0];
          c_q <= '{bus.r4[15:8], bus.r4[7:0], bus.r5[15:8]};
          col_q <= '0;
          cnt_q <= '0;
          a_q <= '{default: '0};
          b_q <= '{default: '0};
          r_q <= '{default: '0};
`ifdef SERPENTINE_EN
          odd_q <= 1'b0;
`endif
          if (!degen) begin
            state_q <= CLEAR;
            busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + ONE;
          if (cnt_q == w_q + ONE) begin
            state_q <= DRAW;
            de_req_q <= 1'b1;
          end
        end
        DRAW: if (fire) begin
          a_q <= a_d;
          b_q <= b_d;
          r_q <= r_d;
          if (last_px) begin
            state_q <= IDLE;
            de_req_q <= 1'b0;
            busy_q <= 1'b0;
          end else if (last_col) begin
            y_q <= y_q + 16'd1;
`ifdef SERPENTINE_EN
            odd_q <= !odd_q;
`else
            col_q <= '0;
`endif
          end else begin
            col_q <= desc ? col_q - ONE : col_q + ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    for (int c = 0; c < 3; c++)
      if (state_q == CLEAR) eb_q[c][cnt_q] <= '0;
      else if (fire && we) eb_q[c][wr_idx] <= wval[c];
  assign bus.ack = ack_q;
  assign bus.busy = busy_q;
  assign bus.de_req = de_req_q;
  assign bus.de_addr = byte_addr[BW-1:2];
  assign bus.de_nbyte = de_req_q ? ~(4'b1 << byte_addr[1:0]) : 4'hF;
  assign bus.de_rnw = 1'b0;
  assign bus.de_w_data = {4{pix}};
endmodule

// File: tb/tb_dither_fill_engine.sv
// tb_dither_fill_engine: randomized fills checked against a 2-D Floyd-Steinberg reference model
module tb_dither_fill_engine;
  localparam int RB = 3, GB = 3, BB = 2, FBW = 640, LM = 640, AW = 18;
`ifdef SERPENTINE_EN
  localparam bit SERP = 1'b1;
`else
  localparam bit SERP = 1'b0;
`endif
  typedef struct {
    logic [AW-1:0] a;
    logic [3:0]    n;
    logic [31:0]   d;
  } xfer_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  dither_fill_engine_if #(.ADDR_W(AW)) bus();
  dither_fill_engine #(.R_BITS(RB), .G_BITS(GB), .B_BITS(BB), .FB_WIDTH(FBW),
    .LINE_MAX(LM), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0;
  int n_ack = 0, n_acc = 0, n_stall = 0, stall_left = 0, ack_mode = 0;
  bit req_seen = 0, prev_stall = 0;
  logic [AW-1:0] p_addr;
  logic [31:0] p_data;
  logic [3:0] p_nbyte;
  xfer_t exp_q [$];
  logic [7:0] obs_d [$];
  logic [AW-1:0] obs_a [$];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Reference: whole-rectangle error field, per-pixel quantise, distribute with bounds discard.
  task automatic model(input int x0, input int y0, input int w, input int h,
                       input logic [15:0] v4, input logic [15:0] v5);
    int cur [3][LM+2];
    int nxt [3][LM+2];
    int nb [3];
    int cin [3];
    int code [3];
    nb = '{RB, GB, BB};
    cin = '{int'(v4[15:8]), int'(v4[7:0]), int'(v5[15:8])};
    foreach (cur[c, x]) cur[c][x] = 0;
    for (int yy = 0; yy < h; yy++) begin
      foreach (nxt[c, x]) nxt[c][x] = 0;
      for (int k = 0; k < w; k++) begin
        int x, s, ba;
        logic [7:0] px;
        s = (SERP && yy % 2 == 1) ? -1 : 1;
        x = s > 0 ? k : w - 1 - k;
        for (int c = 0; c < 3; c++) begin
          int v, q, e, n;
          n = nb[c];
          v = cin[c] + ((cur[c][x] + 8) >>> 4);
          v = v < 0 ? 0 : v > 255 ? 255 : v;
          q = (v + (1 << (7 - n))) >> (8 - n);
          if (q > (1 << n) - 1) q = (1 << n) - 1;
          e = v - (q << (8 - n));
          code[c] = q;
          if (x + s >= 0 && x + s < w) cur[c][x + s] += 7 * e;
          if (yy < h - 1) begin
            if (x - s >= 0 && x - s < w) nxt[c][x - s] += 3 * e;
            nxt[c][x] += 5 * e;
            if (x + s >= 0 && x + s < w) nxt[c][x + s] += e;
          end
        end
        px = 8'((code[0] << (GB + BB)) | (code[1] << BB) | code[2]);
        ba = (x0 + x) + (y0 + yy) * FBW;
        exp_q.push_back('{a: AW'(ba >> 2), n: 4'hF ^ (4'b1 << (ba & 3)), d: {4{px}}});
      end
      cur = nxt;
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (ack_mode == 1) bus.de_ack = $urandom_range(0, 3) != 0;
    else if (ack_mode == 2 && bus.de_req && n_acc == 2 && stall_left > 0) begin
      bus.de_ack = 1'b0;
      stall_left--;
    end else bus.de_ack = 1'b1;
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ack) n_ack++;
      if (bus.de_req) req_seen = 1;
      if (prev_stall) begin
        chk("hold_req", bus.de_req, 1);
        chk("hold_addr", bus.de_addr, p_addr);
        chk("hold_nbyte", bus.de_nbyte, p_nbyte);
        chk("hold_data", bus.de_w_data, p_data);
      end
      prev_stall = bus.de_req && !bus.de_ack;
      if (prev_stall) n_stall++;
      p_addr = bus.de_addr;
      p_nbyte = bus.de_nbyte;
      p_data = bus.de_w_data;
      if (bus.de_req && bus.de_ack) begin
        xfer_t e;
        n_acc++;
        obs_d.push_back(bus.de_w_data[7:0]);
        obs_a.push_back(bus.de_addr);
        chk("xfer_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("addr", bus.de_addr, e.a);
          chk("nbyte", bus.de_nbyte, e.n);
          chk("data", bus.de_w_data, e.d);
          chk("rnw", bus.de_rnw, 0);
        end
      end
    end else prev_stall = 0;
  end
  task automatic start(input int x0, input int y0, input int x1, input int y1,
                       input logic [15:0] v4, input logic [15:0] v5, input int mode);
    exp_q.delete();
    obs_d.delete();
    obs_a.delete();
    n_acc = 0;
    n_stall = 0;
    stall_left = 3;
    req_seen = 0;
    ack_mode = mode;
    if (!(x1 < x0 || y1 < y0 || x1 - x0 + 1 > LM)) model(x0, y0, x1 - x0 + 1, y1 - y0 + 1, v4, v5);
    @(posedge clk);
    #1;
    bus.req = 1'b1;
    bus.r0 = 16'(x0);
    bus.r1 = 16'(y0);
    bus.r2 = 16'(x1);
    bus.r3 = 16'(y1);
    bus.r4 = v4;
    bus.r5 = v5;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
  endtask
  task automatic run_fill(input int x0, input int y0, input int x1, input int y1,
                          input logic [15:0] v4, input logic [15:0] v5, input int mode,
                          input bit poke);
    int acks0, cyc, npx;
    bit degen;
    degen = x1 < x0 || y1 < y0 || x1 - x0 + 1 > LM;
    npx = degen ? 0 : (x1 - x0 + 1) * (y1 - y0 + 1);
    acks0 = n_ack;
    start(x0, y0, x1, y1, v4, v5, mode);
    @(negedge clk);
    chk("ack_pulse", bus.ack, 1);
    chk("busy_start", bus.busy, !degen);
    @(negedge clk);
    chk("ack_width", bus.ack, 0);
    if (poke) begin
      @(posedge clk);
      #1;
      bus.req = 1'b1;
      @(posedge clk);
      #1;
      bus.req = 1'b0;
    end
    cyc = 0;
    while (bus.busy && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_in_time", cyc < 20000, 1);
    repeat (2) @(negedge clk);
    chk("ack_count", n_ack - acks0, 1);
    chk("xfer_count", n_acc, npx);
    chk("left_over", exp_q.size(), 0);
    chk("req_idle", bus.de_req, 0);
    chk("nbyte_idle", bus.de_nbyte, 4'hF);
    if (degen) begin
      chk("degen_no_req", req_seen, 0);
      chk("degen_busy", bus.busy, 0);
    end
  endtask
  initial begin
    int bad, ones, cyc;
    bus.req = 1'b0;
    bus.de_ack = 1'b1;
    {bus.r0, bus.r1, bus.r2, bus.r3, bus.r4, bus.r5} = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", bus.ack, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_de_req", bus.de_req, 0);
    chk("rst_nbyte", bus.de_nbyte, 4'hF);
    run_fill(0, 0, 3, 1, 16'h2020, 16'h4000, 0, 0);
    bad = 0;
    foreach (obs_d[i]) if (obs_d[i] != 8'h25) bad++;
    chk("exact_bytes", bad, 0);
    run_fill(10, 5, 17, 6, 16'hFFFF, 16'hFF00, 0, 0);
    bad = 0;
    foreach (obs_d[i]) if (obs_d[i] != 8'hFF) bad++;
    chk("sat_bytes", bad, 0);
    chk("sat_first_word", obs_a.size() > 0 ? obs_a[0] : '1, 3210 >> 2);
    run_fill(0, 0, 7, 7, 16'h1000, 16'h0000, 0, 1);
    bad = 0;
    ones = 0;
    foreach (obs_d[i]) begin
      if (obs_d[i][4:0] != 0 || obs_d[i][7:5] > 1) bad++;
      if (obs_d[i][7:5] == 1) ones++;
    end
    chk("dens_codes", bad, 0);
    chk("dens_range", ones >= 30 && ones <= 34, 1);
    run_fill(0, 0, 3, 1, 16'h2020, 16'h4000, 2, 0);
    chk("stall_cycles", n_stall, 3);
    start(0, 0, 3, 1, 16'h2020, 16'h4000, 0);
    cyc = 0;
    while (n_acc < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_draw_reached", n_acc >= 3, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_de_req", bus.de_req, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_nbyte", bus.de_nbyte, 4'hF);
    run_fill(0, 0, 3, 1, 16'h2020, 16'h4000, 0, 0);
    run_fill(9, 2, 4, 3, 16'h2020, 16'h4000, 0, 0);
    run_fill(0, 7, 3, 2, 16'h1234, 16'h5600, 0, 0);
    run_fill(0, 0, 640, 0, 16'h8080, 16'h8000, 0, 0);
    for (int i = 0; i < 12; i++) begin
      int x0, y0, w, h;
      x0 = $urandom_range(0, 600);
      y0 = $urandom_range(0, 400);
      w = i == 0 ? 1 : $urandom_range(1, 12);
      h = $urandom_range(1, 4);
      run_fill(x0, y0, x0 + w - 1, y0 + h - 1, 16'($urandom), 16'($urandom), 1, 0);
    end
    run_fill(0, 3, 639, 4, 16'h5A33, 16'hC700, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not complete, %0d vectors applied, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end
endmodule
